// File: rtl/ai_paddle_driver.sv
// Purpose : integrates the AI's per-frame action into the AI paddle centre y, with speed ramp and clamping.
// Latency : tick at edge k -> action sampled at edge k+SETTLE_CYC -> paddle_posy/update_valid at edge k+SETTLE_CYC+1.
// Backpres: none; ticks arriving while a frame is in flight are dropped and flagged in sticky overrun.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   enable            respond to frame ticks when high; hold position otherwise
//   frame_tick        one-cycle pulse per game frame
//   action            1 = stay, 2 = up (+y), 3 = down (-y); other codes invalid
//   paddle_posy       registered paddle centre (signed)
//   speed             current step magnitude
//   update_valid      one-cycle pulse when paddle_posy takes its per-frame value
//   hit_limit         one-cycle pulse with update_valid when the position was clamped
//   overrun           sticky flag: a tick arrived while a frame was still in flight
//   err_cnt           saturating count of invalid actions sampled
module ai_paddle_driver #(
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 480,
  parameter int HALF_PAD   = 40,
  parameter int Y_INIT     = 240,
  parameter int BASE_SPEED = 4,
  parameter int ACCEL      = 2,
  parameter int MAX_SPEED  = 12,
  parameter int SETTLE_CYC = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               frame_tick,
  input  logic [2:0]         action,
  output logic signed [10:0] paddle_posy,
  output logic [3:0]         speed,
  output logic               update_valid,
  output logic               hit_limit,
  output logic               overrun,
  output logic [7:0]         err_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, APPLY} state_t;
  typedef enum logic [1:0] {DIR_STAY, DIR_UP, DIR_DOWN} dir_t;

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  // Clamp bounds for the paddle centre, held in the 12-bit move domain.
  localparam logic signed [11:0] POS_LO = 12'(Y_MIN + HALF_PAD);
  localparam logic signed [11:0] POS_HI = 12'(Y_MAX - HALF_PAD);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         act_q;
  dir_t               last_dir;

  logic               settle_done;
  logic               act_valid;
  dir_t               dir;
  logic [4:0]         spd_sum;
  logic [3:0]         spd_ramp;
  logic [3:0]         spd_new;
  logic signed [11:0] pos_ext;
  logic signed [11:0] step;
  logic signed [11:0] pos_move;
  logic               clamp_lo;
  logic               clamp_hi;
  logic               clamped;
  logic signed [10:0] pos_new;

  assign settle_done = (cnt == CNT_W'(SETTLE_CYC - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (frame_tick && enable) state_d = WAIT;
      WAIT:    if (settle_done)          state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------- move compute
  always_comb begin
    act_valid = 1'b1;
    dir       = DIR_STAY;
    case (act_q)
      3'd1:    dir = DIR_STAY;
      3'd2:    dir = DIR_UP;
      3'd3:    dir = DIR_DOWN;
      default: act_valid = 1'b0;
    endcase

    // Ramp in 5 bits so speed+ACCEL cannot wrap before saturation.
    spd_sum  = {1'b0, speed} + 5'(ACCEL);
    spd_ramp = (spd_sum > 5'(MAX_SPEED)) ? 4'(MAX_SPEED) : spd_sum[3:0];

    if (dir == DIR_STAY)      spd_new = 4'd0;
    else if (dir == last_dir) spd_new = spd_ramp;
    else                      spd_new = 4'(BASE_SPEED);

    // One extra bit keeps y +/- speed from wrapping before the clamp.
    pos_ext = {paddle_posy[10], paddle_posy};
    step    = signed'({8'd0, spd_new});
    case (dir)
      DIR_UP:   pos_move = pos_ext + step;
      DIR_DOWN: pos_move = pos_ext - step;
      default:  pos_move = pos_ext;
    endcase

    clamp_lo = (pos_move < POS_LO);
    clamp_hi = (pos_move > POS_HI);
    clamped  = clamp_lo | clamp_hi;

    if (clamp_hi)      pos_new = POS_HI[10:0];
    else if (clamp_lo) pos_new = POS_LO[10:0];
    else               pos_new = pos_move[10:0];
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      paddle_posy  <= 11'(Y_INIT);
      speed        <= 4'd0;
      last_dir     <= DIR_STAY;
      cnt          <= '0;
      act_q        <= 3'd1;
      update_valid <= 1'b0;
      hit_limit    <= 1'b0;
      overrun      <= 1'b0;
      err_cnt      <= 8'd0;
    end else begin
      update_valid <= 1'b0;
      hit_limit    <= 1'b0;

      // Includes the APPLY cycle: a tick there is not taken as a new frame.
      if (frame_tick && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (settle_done) act_q <= action;
        end
        APPLY: begin
          paddle_posy  <= pos_new;
          update_valid <= 1'b1;
          hit_limit    <= clamped;
          // A clamp stops the paddle so the next frame starts from rest.
          if (clamped) begin
            speed    <= 4'd0;
            last_dir <= DIR_STAY;
          end else begin
            speed    <= spd_new;
            last_dir <= dir;
          end
          if (!act_valid && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ai_paddle_driver.sv
module tb_ai_paddle_driver;

  localparam int S = 3;

  logic               clk;
  logic               rst;
  logic               enable;
  logic               frame_tick;
  logic [2:0]         action;
  logic signed [10:0] paddle_posy;
  logic [3:0]         speed;
  logic               update_valid;
  logic               hit_limit;
  logic               overrun;
  logic [7:0]         err_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model state: position, speed, last direction (0 stay, 1 up, 2 down), error count.
  int m_pos, m_spd, m_last, m_err, m_hit;

  // Observations of one frame.
  int obs_lat, obs_pos, obs_spd, obs_hit, obs_err, obs_uv_after;

  ai_paddle_driver #(.SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick), .action(action),
    .paddle_posy(paddle_posy), .speed(speed), .update_valid(update_valid),
    .hit_limit(hit_limit), .overrun(overrun), .err_cnt(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pos = 240; m_spd = 0; m_last = 0; m_err = 0; m_hit = 0;
  endtask

  task automatic model_apply(input int act);
    int d, s, p;
    m_hit = 0;
    case (act)
      1: d = 0;
      2: d = 1;
      3: d = 2;
      default: begin d = 0; if (m_err < 255) m_err++; end
    endcase
    if (d == 0)           s = 0;
    else if (d == m_last) s = (m_spd + 2 > 12) ? 12 : m_spd + 2;
    else                  s = 4;
    p = m_pos + ((d == 1) ? s : (d == 2) ? -s : 0);
    if (p > 440)     begin p = 440; m_hit = 1; end
    else if (p < 40) begin p = 40;  m_hit = 1; end
    if (m_hit) begin s = 0; d = 0; end
    m_pos = p; m_spd = s; m_last = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_tick = 1'b0;
    step(); step();
    rst = 1'b0;
    model_reset();
  endtask

  // Issue one frame and record what the DUT does; drop_en releases enable right after the tick.
  task automatic run_frame(input logic [2:0] act, input bit drop_en);
    bit got;
    action = act; frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    if (drop_en) enable = 1'b0;
    obs_lat = 0; got = 0;
    while (obs_lat < 20 && !got) begin
      step();
      obs_lat++;
      if (update_valid === 1'b1) got = 1;
    end
    if (!got) obs_lat = -1;
    obs_pos = int'(paddle_posy); obs_spd = int'(speed); obs_hit = int'(hit_limit);
    obs_err = int'(err_cnt);
    step();
    obs_uv_after = int'(update_valid);
    model_apply(int'(act));
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; frame_tick = 1'b0; action = 3'd1;
    step(); step();
    rst = 1'b0;
    model_reset();
    tests++; if (paddle_posy !== 11'sd240) begin fails++; $display("FAIL reset_pos: got %0d expected 240", paddle_posy); end
    tests++; if (speed !== 4'd0) begin fails++; $display("FAIL reset_speed: got %0d expected 0", speed); end
    tests++; if ({update_valid, hit_limit, overrun} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {update_valid, hit_limit, overrun}); end
    tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_ramp();
    int exp_pos[6] = '{244, 250, 258, 268, 280, 292};
    int exp_spd[6] = '{4, 6, 8, 10, 12, 12};
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_frame(3'd2, 1'b0);
      tests++; if (obs_lat != S + 1) begin fails++; $display("FAIL ramp_latency[%0d]: got %0d expected %0d", i, obs_lat, S + 1); end
      tests++; if (obs_pos != exp_pos[i]) begin fails++; $display("FAIL ramp_pos[%0d]: got %0d expected %0d", i, obs_pos, exp_pos[i]); end
      tests++; if (obs_spd != exp_spd[i]) begin fails++; $display("FAIL ramp_speed[%0d]: got %0d expected %0d", i, obs_spd, exp_spd[i]); end
      tests++; if (obs_uv_after != 0) begin fails++; $display("FAIL ramp_pulse_width[%0d]: got %0d expected 0", i, obs_uv_after); end
      repeat (10 - (S + 3)) step();
    end
  endtask

  task automatic test_reverse();
    run_frame(3'd3, 1'b0);
    tests++; if (obs_pos != 288 || obs_spd != 4) begin fails++; $display("FAIL reverse: got pos %0d spd %0d expected pos 288 spd 4", obs_pos, obs_spd); end
  endtask

  task automatic test_clamp();
    int n;
    n = 0;
    do begin
      run_frame(3'd2, 1'b0);
      n++;
      tests++; if (obs_pos != m_pos || obs_spd != m_spd || obs_hit != m_hit) begin fails++; $display("FAIL clamp_up_walk[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", n, obs_pos, obs_spd, obs_hit, m_pos, m_spd, m_hit); end
    end while (obs_hit == 0 && n < 40);
    tests++; if (obs_pos != 440 || obs_spd != 0 || obs_hit != 1) begin fails++; $display("FAIL clamp_top: got pos %0d spd %0d hit %0d expected 440 0 1", obs_pos, obs_spd, obs_hit); end
    run_frame(3'd2, 1'b0);
    tests++; if (obs_pos != 440 || obs_spd != 0 || obs_hit != 1) begin fails++; $display("FAIL clamp_top_again: got pos %0d spd %0d hit %0d expected 440 0 1", obs_pos, obs_spd, obs_hit); end
    n = 0;
    do begin
      run_frame(3'd3, 1'b0);
      n++;
    end while (obs_hit == 0 && n < 60);
    tests++; if (obs_pos != 40 || obs_spd != 0 || obs_hit != 1) begin fails++; $display("FAIL clamp_bottom: got pos %0d spd %0d hit %0d expected 40 0 1", obs_pos, obs_spd, obs_hit); end
  endtask

  task automatic test_invalid();
    int p0;
    run_frame(3'd2, 1'b0);
    p0 = obs_pos;
    run_frame(3'd5, 1'b0);
    tests++; if (obs_lat != S + 1) begin fails++; $display("FAIL invalid5_pulse: got latency %0d expected %0d", obs_lat, S + 1); end
    tests++; if (obs_pos != p0 || obs_spd != 0 || obs_err != 1) begin fails++; $display("FAIL invalid5: got pos %0d spd %0d err %0d expected %0d 0 1", obs_pos, obs_spd, obs_err, p0); end
    run_frame(3'd0, 1'b0);
    tests++; if (obs_pos != p0 || obs_spd != 0 || obs_err != 2) begin fails++; $display("FAIL invalid0: got pos %0d spd %0d err %0d expected %0d 0 2", obs_pos, obs_spd, obs_err, p0); end
  endtask

  task automatic test_overrun();
    int uv;
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_pre: got %b expected 0", overrun); end
    // Second tick one cycle after the first.
    action = 3'd2; frame_tick = 1'b1;
    step();
    step();
    frame_tick = 1'b0;
    uv = (update_valid === 1'b1) ? 1 : 0;
    repeat (15) begin step(); if (update_valid === 1'b1) uv++; end
    model_apply(2);
    tests++; if (uv != 1) begin fails++; $display("FAIL overrun_updates: got %0d expected 1", uv); end
    tests++; if (paddle_posy !== 11'(m_pos)) begin fails++; $display("FAIL overrun_pos: got %0d expected %0d", paddle_posy, m_pos); end
    repeat (5) step();
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    // Tick landing on the APPLY cycle is not a new frame.
    action = 3'd1; frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (S) step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    uv = (update_valid === 1'b1) ? 1 : 0;
    repeat (14) begin step(); if (update_valid === 1'b1) uv++; end
    model_apply(1);
    tests++; if (uv != 1) begin fails++; $display("FAIL apply_tick_updates: got %0d expected 1", uv); end
  endtask

  task automatic test_enable();
    int uv;
    run_frame(3'd3, 1'b1);
    tests++; if (obs_lat != S + 1 || obs_pos != m_pos) begin fails++; $display("FAIL enable_drop_midframe: got lat %0d pos %0d expected %0d %0d", obs_lat, obs_pos, S + 1, m_pos); end
    uv = 0;
    for (int i = 0; i < 4; i++) begin
      action = 3'd2; frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      repeat (S + 4) begin step(); if (update_valid === 1'b1) uv++; end
    end
    tests++; if (uv != 0 || paddle_posy !== 11'(m_pos)) begin fails++; $display("FAIL enable_low_ticks: got %0d updates pos %0d expected 0 updates pos %0d", uv, paddle_posy, m_pos); end
    enable = 1'b1;
  endtask

  task automatic test_reset_abort();
    int uv;
    do_reset();
    action = 3'd2; frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    tests++; if (paddle_posy !== 11'sd240 || speed !== 4'd0 || update_valid !== 1'b0) begin fails++; $display("FAIL abort_state: got pos %0d spd %0d uv %b expected 240 0 0", paddle_posy, speed, update_valid); end
    uv = 0;
    repeat (10) begin step(); if (update_valid === 1'b1) uv++; end
    tests++; if (uv != 0 || paddle_posy !== 11'sd240) begin fails++; $display("FAIL abort_no_update: got %0d updates pos %0d expected 0 updates pos 240", uv, paddle_posy); end
    // The FSM must be back in IDLE and accept the next frame normally.
    run_frame(3'd2, 1'b0);
    tests++; if (obs_lat != S + 1 || obs_pos != 244) begin fails++; $display("FAIL abort_recover: got lat %0d pos %0d expected %0d 244", obs_lat, obs_pos, S + 1); end
  endtask

  task automatic test_random();
    int uv;
    for (int i = 0; i < 60; i++) begin
      logic [2:0] act;
      act = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) != 0) begin
        enable = 1'b1;
        run_frame(act, 1'b0);
        tests++; if (obs_lat != S + 1 || obs_pos != m_pos || obs_spd != m_spd || obs_hit != m_hit || obs_err != m_err) begin
          fails++; $display("FAIL random[%0d] act %0d: got lat %0d pos %0d spd %0d hit %0d err %0d expected %0d %0d %0d %0d %0d",
                            i, act, obs_lat, obs_pos, obs_spd, obs_hit, obs_err, S + 1, m_pos, m_spd, m_hit, m_err);
        end
      end else begin
        enable = 1'b0;
        action = act; frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        uv = 0;
        repeat (S + 3) begin step(); if (update_valid === 1'b1) uv++; end
        tests++; if (uv != 0 || paddle_posy !== 11'(m_pos)) begin fails++; $display("FAIL random_disabled[%0d]: got %0d updates pos %0d expected 0 updates pos %0d", i, uv, paddle_posy, m_pos); end
      end
      repeat ($urandom_range(0, 3)) step();
    end
    enable = 1'b1;
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL random_no_overrun: got %b expected 0", overrun); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; frame_tick = 1'b0; action = 3'd1;
    model_reset();
    test_reset();
    test_ramp();
    test_reverse();
    test_clamp();
    test_invalid();
    test_overrun();
    test_enable();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
